// File: rtl/plate_array.sv
// plate_array: pressure-plate controller for the game playfield.
//
// Tracks the foot point of two player sprites against NUM_PLATES rectangular
// floor plates. Each plate has a per-frame debounce FSM (IDLE/HELD with a
// hold/release counter) and a momentary, latching or toggle output mode.
//
// Optional feature macro: PLATE_PLAYER_MASK_EN
//   defined   -> adds input player_mask; only enabled players occupy a plate
//   undefined -> every player activates every plate
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   frame_tick            one-cycle pulse per frame; occupancy sampled only here
//   p0_x/p0_y, p1_x/p1_y  player centres (10 bit)
//   p0_h, p1_h            player sprite heights (7 bit)
//   plate_x, plate_y      top-left corner per plate, plate k at [10k+9:10k]
//   plate_mode            2 bits per plate: 00 momentary, 01 latch, 10 toggle,
//                         11 momentary
//   clear                 per-plate output clear, acts in any cycle
//   player_mask           (optional) bit 2k enables p0, bit 2k+1 enables p1
//   plate_on              registered plate outputs
//   press_pulse           one-cycle pulse the cycle after each press event
//   any_on                registered OR of next-state plate_on
module plate_array #(
  parameter int unsigned NUM_PLATES  = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned PLATE_W     = 20,
  parameter int unsigned PLATE_H     = 10
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_tick,
  input  logic [9:0]              p0_x,
  input  logic [9:0]              p0_y,
  input  logic [9:0]              p1_x,
  input  logic [9:0]              p1_y,
  input  logic [6:0]              p0_h,
  input  logic [6:0]              p1_h,
  input  logic [10*NUM_PLATES-1:0] plate_x,
  input  logic [10*NUM_PLATES-1:0] plate_y,
  input  logic [2*NUM_PLATES-1:0] plate_mode,
  input  logic [NUM_PLATES-1:0]   clear,
`ifdef PLATE_PLAYER_MASK_EN
  input  logic [2*NUM_PLATES-1:0] player_mask,
`endif
  output logic [NUM_PLATES-1:0]   plate_on,
  output logic [NUM_PLATES-1:0]   press_pulse,
  output logic                    any_on
);

  typedef enum logic {StIdle, StHeld} state_e;

  localparam logic [3:0]  HoldCnt = 4'(HOLD_CYCLES);
  localparam logic [10:0] PlateW  = 11'(PLATE_W);
  localparam logic [10:0] PlateH  = 11'(PLATE_H);

  // ---------------------------------------------------------------------------
  // Foot points. All arithmetic at 11 bits so nothing wraps at screen edges.
  // ---------------------------------------------------------------------------
  logic [6:0]  p0_half, p1_half;
  logic [10:0] p0_sum, p1_sum;
  logic [10:0] p0_fx, p0_fy, p1_fx, p1_fy;
  logic        p0_valid, p1_valid;

  always_comb begin
    p0_half  = p0_h >> 1;
    p1_half  = p1_h >> 1;
    p0_sum   = {1'b0, p0_y} + {4'b0, p0_half};
    p1_sum   = {1'b0, p1_y} + {4'b0, p1_half};
    // A foot point above row 0 would underflow; such a player hits nothing.
    p0_valid = (p0_sum >= 11'd5);
    p1_valid = (p1_sum >= 11'd5);
    p0_fx    = {1'b0, p0_x};
    p1_fx    = {1'b0, p1_x};
    p0_fy    = p0_sum - 11'd5;
    p1_fy    = p1_sum - 11'd5;
  end

  // ---------------------------------------------------------------------------
  // Per-plate hit test and occupancy
  // ---------------------------------------------------------------------------
  logic [NUM_PLATES-1:0] hit0, hit1, occ;
  logic [10:0]           px, py, px_end, py_end;
  logic [2*NUM_PLATES-1:0] en_mask;

`ifdef PLATE_PLAYER_MASK_EN
  assign en_mask = player_mask;
`else
  assign en_mask = '1;
`endif

  always_comb begin
    hit0   = '0;
    hit1   = '0;
    occ    = '0;
    px     = '0;
    py     = '0;
    px_end = '0;
    py_end = '0;
    for (int k = 0; k < int'(NUM_PLATES); k++) begin
      px      = {1'b0, plate_x[10*k +: 10]};
      py      = {1'b0, plate_y[10*k +: 10]};
      px_end  = px + PlateW;
      py_end  = py + PlateH;
      hit0[k] = p0_valid && (p0_fx >= px) && (p0_fx < px_end) &&
                (p0_fy >= py) && (p0_fy < py_end);
      hit1[k] = p1_valid && (p1_fx >= px) && (p1_fx < px_end) &&
                (p1_fy >= py) && (p1_fy < py_end);
      // Two players on one plate are still a single occupancy.
      occ[k]  = (hit0[k] && en_mask[2*k]) || (hit1[k] && en_mask[2*k+1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: state/counter registers
  // ---------------------------------------------------------------------------
  state_e                state_q [NUM_PLATES];
  state_e                state_d [NUM_PLATES];
  logic [3:0]            cnt_q   [NUM_PLATES];
  logic [3:0]            cnt_d   [NUM_PLATES];
  logic [NUM_PLATES-1:0] press, release_ev;
  logic [3:0]            cnt_inc;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < int'(NUM_PLATES); k++) begin
        state_q[k] <= StIdle;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUM_PLATES); k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Next-state: the counter measures consecutive ticks that disagree with the
  // current state; any agreeing tick restarts it.
  always_comb begin
    press      = '0;
    release_ev = '0;
    cnt_inc    = '0;
    for (int k = 0; k < int'(NUM_PLATES); k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      if (frame_tick) begin
        cnt_inc = cnt_q[k] + 4'd1;
        unique case (state_q[k])
          StIdle: begin
            if (occ[k]) begin
              if (cnt_inc == HoldCnt) begin
                press[k]   = 1'b1;
                state_d[k] = StHeld;
                cnt_d[k]   = '0;
              end else begin
                cnt_d[k] = cnt_inc;
              end
            end else begin
              cnt_d[k] = '0;
            end
          end
          StHeld: begin
            if (!occ[k]) begin
              if (cnt_inc == HoldCnt) begin
                release_ev[k] = 1'b1;
                state_d[k]    = StIdle;
                cnt_d[k]      = '0;
              end else begin
                cnt_d[k] = cnt_inc;
              end
            end else begin
              cnt_d[k] = '0;
            end
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mode logic
  // ---------------------------------------------------------------------------
  logic [NUM_PLATES-1:0] on_d;
  logic [1:0]            mode;
  logic                  is_latch, is_toggle;

  always_comb begin
    on_d      = plate_on;
    mode      = '0;
    is_latch  = 1'b0;
    is_toggle = 1'b0;
    for (int k = 0; k < int'(NUM_PLATES); k++) begin
      mode      = plate_mode[2*k +: 2];
      is_latch  = (mode == 2'b01);
      is_toggle = (mode == 2'b10);
      // Release only matters for momentary (00 and 11).
      if (release_ev[k] && !is_latch && !is_toggle) begin
        on_d[k] = 1'b0;
      end
      if (clear[k]) begin
        on_d[k] = 1'b0;
      end
      // A press overrides a same-cycle clear.
      if (press[k]) begin
        on_d[k] = is_toggle ? ~plate_on[k] : 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      plate_on    <= '0;
      press_pulse <= '0;
      any_on      <= 1'b0;
    end else begin
      plate_on    <= on_d;
      press_pulse <= press;
      any_on      <= |on_d;
    end
  end

endmodule

// File: tb/tb_plate_array.sv
// Testbench for plate_array: directed scenarios plus randomized traffic
// checked against a behavioural model of plates, players and debounce rules.
module tb_plate_array;

  localparam int NP   = 3;
  localparam int HOLD = 4;
  localparam int PW   = 20;
  localparam int PH   = 10;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              frame_tick = 1'b0;
  logic [9:0]        p0_x, p0_y, p1_x, p1_y;
  logic [6:0]        p0_h, p1_h;
  logic [10*NP-1:0]  plate_x, plate_y;
  logic [2*NP-1:0]   plate_mode;
  logic [2*NP-1:0]   player_mask;
  logic [NP-1:0]     clear;
  logic [NP-1:0]     plate_on, press_pulse;
  logic              any_on;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;

  // Model state
  bit            m_held   [NP];
  int            m_streak [NP];
  logic [NP-1:0] m_on;
  logic [NP-1:0] exp_on, exp_pulse;
  logic          exp_any;

  always #5 Clk = ~Clk;

  plate_array #(
    .NUM_PLATES (NP),
    .HOLD_CYCLES(HOLD),
    .PLATE_W    (PW),
    .PLATE_H    (PH)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .p0_x       (p0_x),
    .p0_y       (p0_y),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p0_h       (p0_h),
    .p1_h       (p1_h),
    .plate_x    (plate_x),
    .plate_y    (plate_y),
    .plate_mode (plate_mode),
    .clear      (clear),
`ifdef PLATE_PLAYER_MASK_EN
    .player_mask(player_mask),
`endif
    .plate_on   (plate_on),
    .press_pulse(press_pulse),
    .any_on     (any_on)
  );

  // Does a player with centre (x,y) and height h stand on plate (px,py)?
  function automatic bit hit(int x, int y, int h, int px, int py);
    int fy;
    if (y + h / 2 < 5) return 1'b0;
    fy = y + h / 2 - 5;
    return (x >= px) && (x < px + PW) && (fy >= py) && (fy < py + PH);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NP; k++) begin
      m_held[k]   = 1'b0;
      m_streak[k] = 0;
    end
    m_on      = '0;
    exp_on    = '0;
    exp_pulse = '0;
    exp_any   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_cycle();
    bit       occ, pr, rl;
    int       px, py;
    bit [1:0] mode;
    for (int k = 0; k < NP; k++) begin
      pr = 1'b0;
      rl = 1'b0;
      if (frame_tick) begin
        px  = int'(plate_x[10*k +: 10]);
        py  = int'(plate_y[10*k +: 10]);
        occ = (hit(int'(p0_x), int'(p0_y), int'(p0_h), px, py) && player_mask[2*k]) ||
              (hit(int'(p1_x), int'(p1_y), int'(p1_h), px, py) && player_mask[2*k+1]);
        if (occ != m_held[k]) begin
          m_streak[k]++;
          if (m_streak[k] == HOLD) begin
            m_held[k]   = occ;
            m_streak[k] = 0;
            pr = occ;
            rl = !occ;
          end
        end else begin
          m_streak[k] = 0;
        end
      end
      mode = plate_mode[2*k +: 2];
      if (rl && (mode == 2'b00 || mode == 2'b11)) m_on[k] = 1'b0;
      if (clear[k] && !pr) m_on[k] = 1'b0;
      if (pr) m_on[k] = (mode == 2'b10) ? !m_on[k] : 1'b1;
      exp_pulse[k] = pr;
    end
    exp_on  = m_on;
    exp_any = |m_on;
  endtask

  task automatic cyc();
    model_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Put each player on plate 0 or well away from every plate.
  task automatic place(bit on0, bit on1);
    p0_x = on0 ? 10'd150 : 10'd500;
    p0_y = 10'd320;
    p0_h = 7'd20;
    p1_x = on1 ? 10'd145 : 10'd700;
    p1_y = 10'd322;
    p1_h = 7'd20;
  endtask

  // n frames: one tick cycle plus one idle cycle each; counts plate-0 pulses.
  task automatic frames(int n, bit on0, bit on1);
    for (int i = 0; i < n; i++) begin
      place(on0, on1);
      frame_tick = 1'b1;
      cyc();
      pulse_cnt += int'(press_pulse[0]);
      frame_tick = 1'b0;
      cyc();
      pulse_cnt += int'(press_pulse[0]);
    end
  endtask

  task automatic set_plates();
    plate_x = {10'd300, 10'd600, 10'd142};
    plate_y = {10'd600, 10'd100, 10'd322};
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    clear       = '0;
    frame_tick  = 1'b0;
    player_mask = '1;
    set_plates();
    Reset_n = 1'b1;
    pulse_cnt = 0;
  endtask

  task automatic test_reset();
    set_plates();
    plate_mode  = '0;
    player_mask = '1;
    clear       = '0;
    place(1'b1, 1'b1);
    frame_tick = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    total++;
    if (plate_on !== '0) begin
      bad++;
      $display("FAIL reset_plate_on got=%b want=%b", plate_on, {NP{1'b0}});
    end
    total++;
    if (press_pulse !== '0) begin
      bad++;
      $display("FAIL reset_press_pulse got=%b want=%b", press_pulse, {NP{1'b0}});
    end
    total++;
    if (any_on !== 1'b0) begin
      bad++;
      $display("FAIL reset_any_on got=%b want=0", any_on);
    end
  endtask

  task automatic test_momentary();
    do_reset();
    plate_mode = '0;
    frames(3, 1'b1, 1'b0);
    total++;
    if (pulse_cnt != 0 || plate_on[0] !== 1'b0) begin
      bad++;
      $display("FAIL mom_early pulses=%0d on=%b want pulses=0 on=0", pulse_cnt, plate_on[0]);
    end
    place(1'b1, 1'b0);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    total++;
    if (press_pulse[0] !== 1'b1 || plate_on[0] !== 1'b1 || any_on !== 1'b1) begin
      bad++;
      $display("FAIL mom_press pulse=%b on=%b any=%b want 1 1 1",
               press_pulse[0], plate_on[0], any_on);
    end
    cyc();
    total++;
    if (press_pulse[0] !== 1'b0) begin
      bad++;
      $display("FAIL mom_pulse_width got=%b want=0", press_pulse[0]);
    end
    frames(3, 1'b0, 1'b0);
    total++;
    if (plate_on[0] !== 1'b1) begin
      bad++;
      $display("FAIL mom_hold_3_vacant got=%b want=1", plate_on[0]);
    end
    frames(1, 1'b0, 1'b0);
    total++;
    if (plate_on[0] !== 1'b0 || any_on !== 1'b0) begin
      bad++;
      $display("FAIL mom_release on=%b any=%b want 0 0", plate_on[0], any_on);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    plate_mode = '0;
    frames(3, 1'b1, 1'b0);
    frames(1, 1'b0, 1'b0);
    frames(3, 1'b1, 1'b0);
    total++;
    if (pulse_cnt != 0 || plate_on[0] !== 1'b0) begin
      bad++;
      $display("FAIL bounce_no_press pulses=%0d on=%b want 0 0", pulse_cnt, plate_on[0]);
    end
    frames(1, 1'b1, 1'b0);
    total++;
    if (pulse_cnt != 1 || plate_on[0] !== 1'b1) begin
      bad++;
      $display("FAIL bounce_press pulses=%0d on=%b want 1 1", pulse_cnt, plate_on[0]);
    end
  endtask

  task automatic test_latch();
    do_reset();
    plate_mode = 6'b000001;
    frames(4, 1'b1, 1'b0);
    frames(10, 1'b0, 1'b0);
    total++;
    if (plate_on[0] !== 1'b1) begin
      bad++;
      $display("FAIL latch_hold got=%b want=1", plate_on[0]);
    end
    clear[0] = 1'b1;
    cyc();
    clear[0] = 1'b0;
    total++;
    if (plate_on[0] !== 1'b0) begin
      bad++;
      $display("FAIL latch_clear got=%b want=0", plate_on[0]);
    end
    frames(3, 1'b1, 1'b0);
    place(1'b1, 1'b0);
    clear[0]   = 1'b1;
    frame_tick = 1'b1;
    cyc();
    clear[0]   = 1'b0;
    frame_tick = 1'b0;
    total++;
    if (plate_on[0] !== 1'b1 || press_pulse[0] !== 1'b1) begin
      bad++;
      $display("FAIL latch_press_beats_clear on=%b pulse=%b want 1 1",
               plate_on[0], press_pulse[0]);
    end
  endtask

  task automatic test_toggle();
    do_reset();
    plate_mode = 6'b000010;
    frames(4, 1'b1, 1'b0);
    total++;
    if (plate_on[0] !== 1'b1) begin
      bad++;
      $display("FAIL toggle_first got=%b want=1", plate_on[0]);
    end
    frames(4, 1'b0, 1'b0);
    total++;
    if (plate_on[0] !== 1'b1) begin
      bad++;
      $display("FAIL toggle_release_ignored got=%b want=1", plate_on[0]);
    end
    frames(4, 1'b1, 1'b0);
    frames(4, 1'b0, 1'b0);
    total++;
    if (plate_on[0] !== 1'b0 || pulse_cnt != 2) begin
      bad++;
      $display("FAIL toggle_second on=%b pulses=%0d want 0 2", plate_on[0], pulse_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    plate_mode = '0;
    frames(4, 1'b1, 1'b0);
    frames(1, 1'b0, 1'b0);
    place(1'b0, 1'b0);
    frame_tick = 1'b1;
    cyc();
    cyc();
    frame_tick = 1'b0;
    total++;
    if (plate_on[0] !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_before got=%b want=1", plate_on[0]);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    total++;
    if (plate_on !== '0 || press_pulse !== '0 || any_on !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async on=%b pulse=%b any=%b want all 0",
               plate_on, press_pulse, any_on);
    end
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    pulse_cnt = 0;
    frames(3, 1'b1, 1'b0);
    total++;
    if (pulse_cnt != 0 || plate_on[0] !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_count_restart pulses=%0d on=%b want 0 0", pulse_cnt, plate_on[0]);
    end
    frames(1, 1'b1, 1'b0);
    total++;
    if (pulse_cnt != 1 || plate_on[0] !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_repress pulses=%0d on=%b want 1 1", pulse_cnt, plate_on[0]);
    end
  endtask

`ifdef PLATE_PLAYER_MASK_EN
  task automatic test_mask();
    do_reset();
    plate_mode  = '0;
    player_mask = 6'b111110;
    frames(6, 1'b1, 1'b0);
    total++;
    if (pulse_cnt != 0 || plate_on[0] !== 1'b0) begin
      bad++;
      $display("FAIL mask_p0_blocked pulses=%0d on=%b want 0 0", pulse_cnt, plate_on[0]);
    end
    frames(4, 1'b0, 1'b1);
    total++;
    if (pulse_cnt != 1 || plate_on[0] !== 1'b1) begin
      bad++;
      $display("FAIL mask_p1_press pulses=%0d on=%b want 1 1", pulse_cnt, plate_on[0]);
    end
    player_mask = '1;
  endtask
`endif

  // Randomized players hovering around plates, including a plate at the top
  // row (foot-point underflow) and one at the right screen edge.
  task automatic test_random();
    int hold_left = 0;
    int r, k, x, y, h, fy, px, py;
    do_reset();
    plate_x    = {10'd1012, 10'd400, 10'd142};
    plate_y    = {10'd700, 10'd0, 10'd322};
    plate_mode = 6'b100100;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        for (int p = 0; p < 2; p++) begin
          r = $urandom_range(0, 3);
          h = $urandom_range(0, 127);
          if (r == 0) begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
          end else begin
            k  = r - 1;
            px = int'(plate_x[10*k +: 10]);
            py = int'(plate_y[10*k +: 10]);
            x  = px + $urandom_range(0, PW + 5) - 3;
            fy = py + $urandom_range(0, PH + 5) - 3;
            y  = fy + 5 - h / 2;
          end
          if (x < 0) x = 0;
          if (x > 1023) x = 1023;
          if (y < 0) y = 0;
          if (y > 1023) y = 1023;
          if (p == 0) begin
            p0_x = 10'(x); p0_y = 10'(y); p0_h = 7'(h);
          end else begin
            p1_x = 10'(x); p1_y = 10'(y); p1_h = 7'(h);
          end
        end
        hold_left = $urandom_range(3, 40);
`ifdef PLATE_PLAYER_MASK_EN
        if ($urandom_range(0, 3) == 0) player_mask = 6'($urandom);
`endif
      end
      hold_left--;
      frame_tick = ($urandom_range(0, 1) == 0);
      for (int b = 0; b < NP; b++) clear[b] = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) plate_mode = 6'($urandom);
      cyc();
      total++;
      if ({plate_on, press_pulse, any_on} !== {exp_on, exp_pulse, exp_any}) begin
        bad++;
        $display("FAIL random c=%0d on=%b want=%b pulse=%b want=%b any=%b want=%b",
                 c, plate_on, exp_on, press_pulse, exp_pulse, any_on, exp_any);
      end
    end
    frame_tick = 1'b0;
    clear      = '0;
  endtask

  initial begin
    test_reset();
    test_momentary();
    test_bounce();
    test_latch();
    test_toggle();
    test_reset_mid();
`ifdef PLATE_PLAYER_MASK_EN
    test_mask();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
